// File: rtl/elevator_request_queue.sv
// Call-button conditioning (sync, debounce, edge detect), pending-call latch and SCAN target selection.
// Optional return-to-lobby idle timer is built only when ELEVATOR_IDLE_RETURN_EN is defined.
module elevator_request_queue #(
  parameter int FLOORS          = 5,
  parameter int FLOOR_W         = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int IDLE_TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  buttons,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic               serviced,
  output logic [FLOORS-1:0]  pending,
  output logic               req_valid,
  output logic [FLOOR_W-1:0] target_floor,
  output logic               dir_up
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, SERVING} state_t;

  state_t             state, state_next;
  logic [FLOORS-1:0]  sync1, sync2, deb, deb_d;
  logic [CNT_W-1:0]   db_cnt [FLOORS];
  logic [FLOORS-1:0]  rise, set_mask, clear_mask;
  logic               lobby_set;
  logic               found_up, found_dn, at_floor, dir_next;
  logic [FLOOR_W-1:0] up_floor, dn_floor, target_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_d <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      deb_d <= deb;
    end
  end

  // A level is accepted only after it has differed from the debounced value for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < FLOORS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < FLOORS; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb & ~deb_d;

  always_comb begin
    clear_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (serviced && (i == int'(current_floor))) clear_mask[i] = 1'b1;
    end
  end

`ifdef ELEVATOR_IDLE_RETURN_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (serviced || (|pending)) begin
      idle_cnt <= '0;
    end else if ((current_floor != '0) && (idle_cnt != IDLE_W'(IDLE_TIMEOUT))) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign lobby_set = (idle_cnt == IDLE_W'(IDLE_TIMEOUT));
`else
  assign lobby_set = 1'b0;
`endif

  assign set_mask = rise | {{(FLOORS-1){1'b0}}, lobby_set};

  // Service beats a same-cycle press, so a press arriving as the door opens is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending | set_mask) & ~clear_mask;
  end

  always_comb begin
    found_up = 1'b0;
    found_dn = 1'b0;
    at_floor = 1'b0;
    up_floor = '0;
    dn_floor = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(current_floor))) begin
        found_up = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && (i < int'(current_floor))) begin
        found_dn = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
      if (pending[i] && (i == int'(current_floor))) at_floor = 1'b1;
    end
  end

  // SCAN: keep going while calls remain ahead, otherwise reverse; with no calls everything holds.
  always_comb begin
    state_next  = (|pending) ? SERVING : IDLE;
    dir_next    = dir_up;
    target_next = target_floor;
    if (dir_up) begin
      if (found_up) begin
        target_next = up_floor;
      end else if (found_dn) begin
        dir_next    = 1'b0;
        target_next = dn_floor;
      end else if (at_floor) begin
        target_next = current_floor;
      end
    end else begin
      if (found_dn) begin
        target_next = dn_floor;
      end else if (found_up) begin
        dir_next    = 1'b1;
        target_next = up_floor;
      end else if (at_floor) begin
        target_next = current_floor;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dir_up       <= 1'b1;
      target_floor <= '0;
    end else begin
      state        <= state_next;
      dir_up       <= dir_next;
      target_floor <= target_next;
    end
  end

  assign req_valid = (state == SERVING);

endmodule

// File: tb/tb_elevator_request_queue.sv
// Self-checking bench for elevator_request_queue: table-driven vectors plus hand-timed corner sequences,
// all expectations routed through a scoreboard queue.
module tb_elevator_request_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] buttons;
  logic [2:0] current_floor;
  logic       serviced;
  logic [4:0] pending;
  logic       req_valid;
  logic [2:0] target_floor;
  logic       dir_up;

  int checks = 0;
  int errors = 0;

  elevator_request_queue #(
    .FLOORS(5), .FLOOR_W(3), .DEBOUNCE_CYCLES(4), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .current_floor(current_floor),
    .serviced(serviced), .pending(pending), .req_valid(req_valid),
    .target_floor(target_floor), .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] buttons;
    logic [2:0] floor;
    logic       svc;
    int         cycles;
    logic [4:0] pend;
    logic       rv;
    logic [2:0] tgt;
    logic       dir;
    bit         all;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] pend;
    logic       rv;
    logic [2:0] tgt;
    logic       dir;
    bit         all;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic pushExpect(input string name, input logic [4:0] p, input logic r,
                            input logic [2:0] t, input logic d, input bit all);
    exp_t e;
    e.name = name; e.pend = p; e.rv = r; e.tgt = t; e.dir = d; e.all = all;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL scoreboard: empty queue, got nothing want an entry");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (pending !== e.pend) begin
      errors++;
      $display("[TB] FAIL %s pending: got %b want %b", e.name, pending, e.pend);
    end
    if (e.all) begin
      checks++;
      if (req_valid !== e.rv) begin
        errors++;
        $display("[TB] FAIL %s req_valid: got %b want %b", e.name, req_valid, e.rv);
      end
      checks++;
      if (target_floor !== e.tgt) begin
        errors++;
        $display("[TB] FAIL %s target_floor: got %0d want %0d", e.name, target_floor, e.tgt);
      end
      checks++;
      if (dir_up !== e.dir) begin
        errors++;
        $display("[TB] FAIL %s dir_up: got %b want %b", e.name, dir_up, e.dir);
      end
    end
  endtask

  // serviced is a single-cycle pulse on the first edge of each vector
  task automatic applyStimulus(input vec_t v, input string name);
    buttons       = v.buttons;
    current_floor = v.floor;
    serviced      = v.svc;
    for (int c = 0; c < v.cycles; c++) begin
      @(posedge clk);
      @(negedge clk);
      serviced = 1'b0;
    end
    pushExpect(name, v.pend, v.rv, v.tgt, v.dir, v.all);
  endtask

  task automatic waitCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;

    //              buttons   flr  svc cyc  pend     rv    tgt   dir   all
    vecs[0]  = '{5'b00000, 3'd3, 1'b1, 3,  5'b00000, 1'b0, 3'd3, 1'b1, 1'b1};
    vecs[1]  = '{5'b00100, 3'd3, 1'b0, 2,  5'b00000, 1'b0, 3'd3, 1'b1, 1'b1};
    vecs[2]  = '{5'b00000, 3'd3, 1'b0, 10, 5'b00000, 1'b0, 3'd3, 1'b1, 1'b1};
    vecs[3]  = '{5'b10001, 3'd2, 1'b0, 9,  5'b10001, 1'b1, 3'd4, 1'b1, 1'b1};
    vecs[4]  = '{5'b00000, 3'd2, 1'b0, 3,  5'b10001, 1'b1, 3'd4, 1'b1, 1'b1};
    vecs[5]  = '{5'b00000, 3'd4, 1'b1, 3,  5'b00001, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[6]  = '{5'b00000, 3'd6, 1'b1, 3,  5'b00001, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[7]  = '{5'b00000, 3'd0, 1'b0, 2,  5'b00001, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[8]  = '{5'b00000, 3'd0, 1'b1, 3,  5'b00000, 1'b0, 3'd0, 1'b0, 1'b1};
    vecs[9]  = '{5'b00010, 3'd4, 1'b0, 9,  5'b00010, 1'b1, 3'd1, 1'b0, 1'b1};
    vecs[10] = '{5'b00000, 3'd0, 1'b0, 3,  5'b00010, 1'b1, 3'd1, 1'b1, 1'b1};
    vecs[11] = '{5'b00000, 3'd1, 1'b1, 3,  5'b00000, 1'b0, 3'd1, 1'b1, 1'b1};

    rst_n = 1'b0;
    buttons = '0;
    current_floor = '0;
    serviced = 1'b0;
    waitCycles(2);
    pushExpect("reset", 5'b00000, 1'b0, 3'd0, 1'b1, 1'b1);
    checkOutput();
    rst_n = 1'b1;
    waitCycles(1);

    $display("[TB] held press on floor 3, cycle-exact latency");
    buttons = 5'b01000;
    for (int e = 0; e <= 7; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 5) begin
        pushExpect("latency_e5", 5'b00000, 1'b0, 3'd0, 1'b1, 1'b1);
        checkOutput();
      end else if (e == 6) begin
        pushExpect("latency_e6", 5'b01000, 1'b0, 3'd0, 1'b1, 1'b1);
        checkOutput();
      end else if (e == 7) begin
        pushExpect("latency_e7", 5'b01000, 1'b1, 3'd3, 1'b1, 1'b1);
        checkOutput();
      end
    end

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput();
    end
    waitCycles(8);

    $display("[TB] press on floor 1 lands on the service cycle");
    current_floor = 3'd0;
    buttons = 5'b00010;
    for (int c = 0; c < 6; c++) @(posedge clk);
    @(negedge clk);
    current_floor = 3'd1;
    serviced = 1'b1;
    @(posedge clk);
    @(negedge clk);
    serviced = 1'b0;
    pushExpect("clear_wins", 5'b00000, 1'b0, 3'd1, 1'b1, 1'b0);
    checkOutput();
    waitCycles(8);
    pushExpect("held_no_reset", 5'b00000, 1'b0, 3'd1, 1'b1, 1'b1);
    checkOutput();
    buttons = 5'b00000;
    current_floor = 3'd0;
    waitCycles(8);

    $display("[TB] asynchronous reset with calls outstanding");
    buttons = 5'b10110;
    waitCycles(9);
    buttons = 5'b00000;
    waitCycles(2);
    pushExpect("before_reset", 5'b10110, 1'b1, 3'd1, 1'b1, 1'b1);
    checkOutput();
    #2;
    rst_n = 1'b0;
    #1;
    pushExpect("async_reset", 5'b00000, 1'b0, 3'd0, 1'b1, 1'b1);
    checkOutput();
    current_floor = 3'd3;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ELEVATOR_IDLE_RETURN_EN
    $display("[TB] idle return to lobby enabled");
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (pending[0]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL lobby_timeout: got pending %b want bit 0 set within 20 cycles", pending);
    end
    waitCycles(2);
    pushExpect("lobby_target", 5'b00001, 1'b1, 3'd0, 1'b0, 1'b1);
    checkOutput();
`else
    $display("[TB] idle return to lobby disabled");
    found = 1'b0;
    waitCycles(30);
    pushExpect("no_lobby", 5'b00000, 1'b0, 3'd0, 1'b1, 1'b1);
    checkOutput();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
